// File: rtl/uart_pkg.sv
// uart_pkg: encodings and helpers shared by the UART transmitter and receiver.
// Frame code 101..111 falls back to 8 data bits; parity 11 means none.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam logic [2:0] FRAME_5bit = 3'b000;
    localparam logic [2:0] FRAME_6bit = 3'b001;
    localparam logic [2:0] FRAME_7bit = 3'b010;
    localparam logic [2:0] FRAME_8bit = 3'b011;
    localparam logic [2:0] FRAME_9bit = 3'b100;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP_1,
        RX_STOP_2,
        RX_DONE
    } rx_state_e;

    // Number of data bits carried by a frame-size code.
    function automatic logic [3:0] frame_bits(input logic [2:0] code);
        case (code)
            FRAME_5bit: frame_bits = 4'd5;
            FRAME_6bit: frame_bits = 4'd6;
            FRAME_7bit: frame_bits = 4'd7;
            FRAME_9bit: frame_bits = 4'd9;
            default:    frame_bits = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for the asynchronous serial line.
// Reset value is a parameter so an idle-high line resets to 1.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/recv.sv
// recv: UART receiver, oversampled by i_stick, 5-9 data bits, parity, 1/2 stop.
// Define RECV_BREAK_DETECT_EN to report an all-zero frame as a break.
module recv
    import uart_pkg::*;
#(
    parameter int SIZE_DATA     = 9,
    parameter int OVER_SAMPLING = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stick,
    input  logic                 i_rx_en,
    input  logic [2:0]           i_size_frame,
    input  logic [1:0]           i_parity_bit,
    input  logic                 i_stop_bit,
    input  logic                 i_data_rx,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_done_rx,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break
);

    localparam int CW = $clog2(OVER_SAMPLING);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVER_SAMPLING / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVER_SAMPLING - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [3:0]           index_q, index_d;
    logic [SIZE_DATA-1:0] shift_q, shift_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic [SIZE_DATA-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 frame_err_q, frame_err_d;
    logic                 has_par, mid_bit, go_done, armed;
    logic [3:0]           nbits;
`ifdef RECV_BREAK_DETECT_EN
    logic                 brk_q, brk_d;
    logic                 break_q, break_d;
    logic                 wait_high_q, wait_high_d;
    assign armed   = !wait_high_q;
    assign o_break = break_q;
`else
    assign armed   = 1'b1;
    assign o_break = 1'b0;
`endif

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_data_rx),
        .o_q  (rx_s)
    );

    assign has_par = (par_q == PARITY_ODD) || (par_q == PARITY_EVEN);
    assign nbits   = frame_bits(size_q);
    assign mid_bit = i_stick && (count_q == FULL_LAST);

    // Next-state, sampling and output-capture logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        index_d     = index_q;
        shift_d     = shift_q;
        size_d      = size_q;
        par_d       = par_q;
        stop_d      = stop_q;
        par_bit_d   = par_bit_q;
        ferr_d      = ferr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        frame_err_d = frame_err_q;
        go_done     = 1'b0;
`ifdef RECV_BREAK_DETECT_EN
        brk_d       = brk_q;
        break_d     = break_q;
        wait_high_d = wait_high_q;
`endif
        if (i_stick) count_d = count_q + CW'(1);
        unique case (state_q)
            RX_IDLE: begin
                count_d = '0;
                index_d = '0;
`ifdef RECV_BREAK_DETECT_EN
                if (rx_s) wait_high_d = 1'b0;
                brk_d = 1'b0;
`endif
                if (i_rx_en && !rx_s && armed) begin
                    state_d   = RX_START;
                    shift_d   = '0;
                    size_d    = i_size_frame;
                    par_d     = i_parity_bit;
                    stop_d    = i_stop_bit;
                    par_bit_d = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            RX_START: begin
                if (i_stick && count_q == HALF_LAST) begin
                    count_d = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (mid_bit) begin
                    count_d = '0;
                    if (int'(index_q) < SIZE_DATA) shift_d[index_q] = rx_s;
                    index_d = index_q + 4'd1;
                    if (index_q == nbits - 4'd1)
                        state_d = has_par ? RX_PARITY : RX_STOP_1;
                end
            end
            RX_PARITY: begin
                if (mid_bit) begin
                    count_d   = '0;
                    par_bit_d = rx_s;
                    state_d   = RX_STOP_1;
                end
            end
            RX_STOP_1: begin
                if (mid_bit) begin
                    count_d = '0;
                    ferr_d  = !rx_s;
`ifdef RECV_BREAK_DETECT_EN
                    brk_d = !rx_s && (shift_q == '0) && !(has_par && par_bit_q);
`endif
                    if (stop_q) state_d = RX_STOP_2;
                    else        go_done = 1'b1;
                end
            end
            RX_STOP_2: begin
                if (mid_bit) begin
                    count_d = '0;
                    ferr_d  = ferr_q | !rx_s;
                    go_done = 1'b1;
                end
            end
            RX_DONE: begin
                count_d = '0;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
        if (go_done) begin
            state_d = RX_DONE;
            done_d  = 1'b1;
            data_d  = shift_q;
            perr_d  = has_par &&
                      (par_bit_q != ((^shift_q) ^ (par_q == PARITY_ODD)));
`ifdef RECV_BREAK_DETECT_EN
            break_d     = brk_d;
            frame_err_d = brk_d ? 1'b0 : ferr_d;
            if (brk_d) wait_high_d = 1'b1;
`else
            frame_err_d = ferr_d;
`endif
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RX_IDLE;
            count_q     <= '0;
            index_q     <= '0;
            shift_q     <= '0;
            size_q      <= '0;
            par_q       <= '0;
            stop_q      <= 1'b0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RECV_BREAK_DETECT_EN
            brk_q       <= 1'b0;
            break_q     <= 1'b0;
            wait_high_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            size_q      <= size_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
`ifdef RECV_BREAK_DETECT_EN
            brk_q       <= brk_d;
            break_q     <= break_d;
            wait_high_q <= wait_high_d;
`endif
        end
    end

    assign o_data       = data_q;
    assign o_done_rx    = done_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_recv.sv
// tb_recv: self-checking bench for the UART receiver.
// Table vectors, corner sequences and randomized frames against a frame model.
module tb_recv;

    localparam int OS = 16;
    localparam int SD = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          stick = 1'b0;
    logic          rx_en;
    logic [2:0]    size_frame;
    logic [1:0]    parity;
    logic          stop_bit;
    logic          line;
    logic [SD-1:0] data;
    logic          done, perr, ferr, brk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [SD-1:0] d;
        logic          pe;
        logic          fe;
        logic          bk;
    } obs_t;

    typedef struct {
        logic [2:0]    sz;
        logic [1:0]    par;
        logic          two;
        logic [SD-1:0] d;
        logic          flip;
        logic          s1;
        logic          s2;
        logic [SD-1:0] ed;
        logic          epe;
        logic          efe;
    } vec_t;

    obs_t q[$];
    vec_t vt[$];

    recv #(.SIZE_DATA(SD), .OVER_SAMPLING(OS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stick     (stick),
        .i_rx_en     (rx_en),
        .i_size_frame(size_frame),
        .i_parity_bit(parity),
        .i_stop_bit  (stop_bit),
        .i_data_rx   (line),
        .o_data      (data),
        .o_done_rx   (done),
        .o_parity_err(perr),
        .o_frame_err (ferr),
        .o_break     (brk)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        stick = ~stick;
    end

    always @(negedge clk) begin
        if (done) q.push_back('{data, perr, ferr, brk});
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!stick) @(posedge clk);
        end
        #1;
    endtask

    task automatic bit_out(input logic v, input int n);
        line = v;
        ticks(n);
    endtask

    function automatic int nb(input logic [2:0] s);
        case (s)
            3'd0: return 5;
            3'd1: return 6;
            3'd2: return 7;
            3'd4: return 9;
            default: return 8;
        endcase
    endfunction

    function automatic logic has_p(input logic [1:0] p);
        return (p == 2'b01) || (p == 2'b10);
    endfunction

    // Parity bit on the wire: makes the count of ones even (even) or odd (odd).
    function automatic logic pbit(input logic [1:0] p, input logic [SD-1:0] d,
                                  input logic [2:0] sz, input logic flip);
        int ones;
        logic v;
        ones = 0;
        for (int i = 0; i < nb(sz); i++) ones += int'(d[i]);
        v = (p == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return v ^ flip;
    endfunction

    task automatic send(input logic [2:0] sz, input logic [1:0] par,
                        input logic two, input logic [SD-1:0] d,
                        input logic flip, input logic s1, input logic s2);
        size_frame = sz;
        parity     = par;
        stop_bit   = two;
        bit_out(1'b0, OS);
        size_frame = 3'($urandom);
        parity     = 2'($urandom);
        stop_bit   = 1'($urandom);
        for (int i = 0; i < nb(sz); i++) bit_out(d[i], OS);
        if (has_p(par)) bit_out(pbit(par, d, sz, flip), OS);
        if (two) begin
            bit_out(s1, OS);
            bit_out(s2, s2 ? OS : 11);
        end else begin
            bit_out(s1, s1 ? OS : 11);
        end
        line = 1'b1;
        ticks(2 * OS);
    endtask

    function automatic obs_t model(input logic [2:0] sz, input logic [1:0] par,
                                   input logic two, input logic [SD-1:0] d,
                                   input logic flip, input logic s1,
                                   input logic s2);
        obs_t o;
        int   n;
        logic is_brk;
        n      = nb(sz);
        o.d    = d & SD'((1 << n) - 1);
        o.pe   = has_p(par) && flip;
        o.fe   = !s1 || (two && !s2);
        o.bk   = 1'b0;
        is_brk = (o.d == '0) && !s1 &&
                 !(has_p(par) && pbit(par, d, sz, flip));
`ifdef RECV_BREAK_DETECT_EN
        if (is_brk) begin
            o.bk = 1'b1;
            o.fe = 1'b0;
        end
`else
        if (is_brk) o.bk = 1'b0;
`endif
        return o;
    endfunction

    task automatic check_one(input string nm, input obs_t e);
        chk({nm, "_count"}, q.size(), 1);
        if (q.size() > 0) begin
            chk({nm, "_data"}, q[0].d, e.d);
            chk({nm, "_perr"}, q[0].pe, e.pe);
            chk({nm, "_ferr"}, q[0].fe, e.fe);
            chk({nm, "_brk"}, q[0].bk, e.bk);
        end
        q.delete();
    endtask

    initial begin
        obs_t e;
        logic [2:0] sz;
        logic [1:0] pr;
        logic tw, fl, a, b;
        logic [SD-1:0] d;

        rst = 1'b1; rx_en = 1'b1; line = 1'b1;
        size_frame = 3'd3; parity = 2'd0; stop_bit = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_done", done, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_brk", brk, 0);
        ticks(OS);

        vt.push_back('{3'd3, 2'b00, 1'b0, 9'h0A5, 0, 1, 1, 9'h0A5, 0, 0});
        vt.push_back('{3'd2, 2'b10, 1'b1, 9'h055, 0, 1, 1, 9'h055, 0, 0});
        vt.push_back('{3'd2, 2'b10, 1'b1, 9'h055, 1, 1, 1, 9'h055, 1, 0});
        vt.push_back('{3'd4, 2'b01, 1'b0, 9'h1FF, 0, 0, 1, 9'h1FF, 0, 1});
        vt.push_back('{3'd0, 2'b00, 1'b0, 9'h1FF, 0, 1, 1, 9'h01F, 0, 0});
        vt.push_back('{3'd1, 2'b01, 1'b0, 9'h02A, 0, 1, 1, 9'h02A, 0, 0});
        vt.push_back('{3'd7, 2'b00, 1'b0, 9'h1C3, 0, 1, 1, 9'h0C3, 0, 0});
        vt.push_back('{3'd3, 2'b11, 1'b1, 9'h081, 1, 1, 1, 9'h081, 0, 0});
        vt.push_back('{3'd3, 2'b10, 1'b1, 9'h00F, 0, 1, 0, 9'h00F, 0, 1});
        foreach (vt[i]) begin
            send(vt[i].sz, vt[i].par, vt[i].two, vt[i].d,
                 vt[i].flip, vt[i].s1, vt[i].s2);
            check_one($sformatf("vec%0d", i),
                      '{vt[i].ed, vt[i].epe, vt[i].efe, 1'b0});
        end

        // Glitch shorter than half a bit is not a start bit.
        line = 1'b0;
        ticks(4);
        line = 1'b1;
        ticks(2 * OS);
        chk("glitch_nodone", q.size(), 0);
        send(3'd3, 2'b00, 1'b0, 9'h03C, 0, 1, 1);
        check_one("after_glitch", '{9'h03C, 1'b0, 1'b0, 1'b0});

        // Receiver disabled: frames are ignored.
        rx_en = 1'b0;
        send(3'd3, 2'b00, 1'b0, 9'h077, 0, 1, 1);
        chk("disabled_nodone", q.size(), 0);
        rx_en = 1'b1;

        // Reset during data bit 3.
        size_frame = 3'd3; parity = 2'b00; stop_bit = 1'b0;
        d = 9'h0B6;
        bit_out(1'b0, OS);
        for (int i = 0; i < 3; i++) bit_out(d[i], OS);
        bit_out(d[3], 8);
        @(posedge clk);
        #1 rst = 1'b1; line = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_data", data, 0);
        chk("midrst_done", done, 0);
        chk("midrst_flags", {perr, ferr, brk}, 0);
        ticks(12 * OS);
        chk("midrst_nodone", q.size(), 0);
        send(3'd0, 2'b00, 1'b0, 9'h015, 0, 1, 1);
        check_one("after_rst", '{9'h015, 1'b0, 1'b0, 1'b0});

        // Line held low for 12 bit times.
        size_frame = 3'd3; parity = 2'b00; stop_bit = 1'b0;
        line = 1'b0;
        ticks(12 * OS);
`ifdef RECV_BREAK_DETECT_EN
        chk("break_single", q.size(), 1);
`endif
        line = 1'b1;
        ticks(14 * OS);
`ifdef RECV_BREAK_DETECT_EN
        check_one("break", '{9'h000, 1'b0, 1'b0, 1'b1});
`else
        chk("break_seen", q.size() >= 1, 1);
        if (q.size() > 0) begin
            chk("break_data", q[0].d, 0);
            chk("break_ferr", q[0].fe, 1);
            chk("break_brk", q[0].bk, 0);
        end
        q.delete();
`endif
        send(3'd3, 2'b01, 1'b0, 9'h0E1, 0, 1, 1);
        check_one("after_break", '{9'h0E1, 1'b0, 1'b0, 1'b0});

        // Randomized frames against the model.
        for (int k = 0; k < 30; k++) begin
            sz = 3'($urandom);
            pr = 2'($urandom);
            tw = 1'($urandom);
            d  = ($urandom_range(0, 5) == 0) ? '0 : SD'($urandom);
            fl = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 7) != 0);
            b  = ($urandom_range(0, 7) != 0);
            e  = model(sz, pr, tw, d, fl, a, b);
            send(sz, pr, tw, d, fl, a, b);
            check_one($sformatf("rnd%0d", k), e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
